// File: rtl/jesd_pattern_pkg.sv
// Shared types, phase encodings and the per-sample pattern function for the
// JESD TX pattern sequencer (optional loop mode: JESD_PATTERN_LOOP_EN).
package jesd_pattern_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ID   = 2'd1,
    ST_RAMP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] PHASE_IDLE = 2'd0;
  localparam logic [1:0] PHASE_ID   = 2'd1;
  localparam logic [1:0] PHASE_RAMP = 2'd2;
  localparam logic [1:0] PHASE_DONE = 2'd3;

  // Widest sample container the pattern function can build; callers truncate.
  localparam int MAX_NP = 64;

  function automatic logic [1:0] phase_of(input state_t st);
    logic [1:0] ph;
    case (st)
      ST_ID:   ph = PHASE_ID;
      ST_RAMP: ph = PHASE_RAMP;
      ST_DONE: ph = PHASE_DONE;
      default: ph = PHASE_IDLE;
    endcase
    return ph;
  endfunction

  // ID: channel nibble replicated over the container.
  // RAMP: channel nibble on top, (count + index) mod 256 in the low byte.
  function automatic logic [MAX_NP-1:0] pattern_sample(
    input logic [1:0] ph,
    input logic [3:0] ch,
    input logic [7:0] idx,
    input logic [7:0] cnt_lsb,
    input int         np
  );
    logic [MAX_NP-1:0] s;
    s = '0;
    if (ph == PHASE_ID) begin
      for (int k = 0; k < MAX_NP / 4; k++) begin
        if (k < np / 4) s[4*k +: 4] = ch;
      end
    end else if (ph == PHASE_RAMP) begin
      s[7:0]      = cnt_lsb + idx;
      s[np-4 +: 4] = ch;
    end
    return s;
  endfunction

endpackage

// File: rtl/jesd_pattern_sample_gen.sv
// Registered builder of the full dac_data word; loads the beat the FSM will
// present next, clears to zero on abort.
module jesd_pattern_sample_gen
  import jesd_pattern_pkg::*;
#(
  parameter int NUM_CHANNELS        = 4,
  parameter int SAMPLES_PER_CHANNEL = 2,
  parameter int DMA_NP              = 16
) (
  input  logic                                              clk,
  input  logic                                              resetn,
  input  logic                                              load,
  input  logic                                              clear,
  input  logic [1:0]                                        phase,
  input  logic [7:0]                                        cnt_lsb,
  output logic [NUM_CHANNELS*SAMPLES_PER_CHANNEL*DMA_NP-1:0] data
);

  localparam int W = NUM_CHANNELS * SAMPLES_PER_CHANNEL * DMA_NP;

  logic [W-1:0] word_next;
  logic [W-1:0] data_reg;

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
    for (genvar gj = 0; gj < SAMPLES_PER_CHANNEL; gj++) begin : g_smp
      assign word_next[DMA_NP*(SAMPLES_PER_CHANNEL*gi+gj) +: DMA_NP] =
        DMA_NP'(pattern_sample(phase, 4'(gi), 8'(gj), cnt_lsb, DMA_NP));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    data_reg <= '0;
    else if (clear) data_reg <= '0;
    else if (load)  data_reg <= word_next;
  end

  assign data = data_reg;

endmodule

// File: rtl/jesd_tx_pattern_sequencer.sv
// Handshaked two-phase (channel ID, then tagged ramp) TX test pattern source.
// Define JESD_PATTERN_LOOP_EN to loop RAMP back to ID instead of ending in DONE.
module jesd_tx_pattern_sequencer
  import jesd_pattern_pkg::*;
#(
  parameter int NUM_CHANNELS        = 4,
  parameter int SAMPLES_PER_CHANNEL = 2,
  parameter int DMA_NP              = 16,
  parameter int PHASE_BEATS         = 4
) (
  input  logic                                              clk,
  input  logic                                              resetn,
  input  logic                                              start,
  input  logic                                              stop,
  input  logic                                              dac_ready,
  output logic                                              dac_valid,
  output logic [NUM_CHANNELS*SAMPLES_PER_CHANNEL*DMA_NP-1:0] dac_data,
  output logic [1:0]                                        phase,
  output logic                                              busy,
  output logic                                              done
);

  localparam logic [15:0] LAST_BEAT = 16'(PHASE_BEATS - 1);
  localparam logic [15:0] CNT_STEP  = 16'(SAMPLES_PER_CHANNEL);

  state_t      state_reg, state_next;
  logic [15:0] beat_cnt_reg, beat_cnt_next;
  logic [15:0] sample_cnt_reg, sample_cnt_next;
  logic        gen_load, gen_clear;
  logic        accept, last_beat;

  assign accept    = dac_valid & dac_ready;
  assign last_beat = (beat_cnt_reg == LAST_BEAT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= ST_IDLE;
      beat_cnt_reg   <= '0;
      sample_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      beat_cnt_reg   <= beat_cnt_next;
      sample_cnt_reg <= sample_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    beat_cnt_next   = beat_cnt_reg;
    sample_cnt_next = sample_cnt_reg;
    gen_load        = 1'b0;
    gen_clear       = 1'b0;
    if (stop) begin
      state_next      = ST_IDLE;
      beat_cnt_next   = '0;
      sample_cnt_next = '0;
      gen_clear       = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_next      = ST_ID;
            beat_cnt_next   = '0;
            sample_cnt_next = '0;
            gen_load        = 1'b1;
          end
        end
        ST_ID: begin
          if (accept) begin
            sample_cnt_next = sample_cnt_reg + CNT_STEP;
            gen_load        = 1'b1;
            if (last_beat) begin
              state_next    = ST_RAMP;
              beat_cnt_next = '0;
            end else begin
              beat_cnt_next = beat_cnt_reg + 16'd1;
            end
          end
        end
        ST_RAMP: begin
          if (accept) begin
            sample_cnt_next = sample_cnt_reg + CNT_STEP;
            if (last_beat) begin
              beat_cnt_next = '0;
`ifdef JESD_PATTERN_LOOP_EN
              state_next    = ST_ID;
              gen_load      = 1'b1;
`else
              // dac_data deliberately keeps the final ramp beat in DONE
              state_next    = ST_DONE;
`endif
            end else begin
              beat_cnt_next = beat_cnt_reg + 16'd1;
              gen_load      = 1'b1;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  jesd_pattern_sample_gen #(
    .NUM_CHANNELS       (NUM_CHANNELS),
    .SAMPLES_PER_CHANNEL(SAMPLES_PER_CHANNEL),
    .DMA_NP             (DMA_NP)
  ) u_sample_gen (
    .clk    (clk),
    .resetn (resetn),
    .load   (gen_load),
    .clear  (gen_clear),
    .phase  (phase_of(state_next)),
    .cnt_lsb(sample_cnt_next[7:0]),
    .data   (dac_data)
  );

  assign phase     = phase_of(state_reg);
  assign busy      = (state_reg == ST_ID) || (state_reg == ST_RAMP);
  assign dac_valid = busy;
  assign done      = (state_reg == ST_DONE);

endmodule

// File: doc/jesd_tx_pattern_sequencer.md
# jesd_tx_pattern_sequencer

Sequences the transmit-side test data for JESD loopback systems, replacing free-running bench stimulus with a controlled, handshaked pattern source. It drives the per-channel DAC sample bus into the TX transport layer through two phases: a channel-identification phase, then a channel-tagged ramp phase. The receive side can then check both lane/channel mapping and sample ordering. It sits between the test controller (start/stop) and the TX transport/DAC data input, in the device clock domain.

## Interface
- NUM_CHANNELS, 4: converters M, 1..16.
- SAMPLES_PER_CHANNEL, 2: samples per channel per beat, ≥1.
- DMA_NP, 16: sample container width, multiple of 4, ≥12.
- PHASE_BEATS, 4: accepted beats per phase, 1..65535.
- clk  in  1  device clock; all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a sequence.
- stop  in  1  single-cycle abort.
- dac_ready  in  1  transport accepts the current beat.
- dac_valid  out  1  dac_data holds a valid beat.
- dac_data  out  NUM_CHANNELS*SAMPLES_PER_CHANNEL*DMA_NP  samples; channel i, sample j at bit offset DMA_NP*(SAMPLES_PER_CHANNEL*i+j).
- phase  out  2  0 idle, 1 ID, 2 ramp, 3 done.
- busy  out  1  high in ID or RAMP.
- done  out  1  high in DONE until next start or stop.

## Operation
- States: IDLE, ID, RAMP, DONE.
- IDLE: start=1 and stop=0 → ID. sample_cnt, beat_cnt cleared. dac_data loaded with beat 0.
- A beat is accepted when dac_valid & dac_ready. Each accepted beat increments beat_cnt and adds SAMPLES_PER_CHANNEL to sample_cnt.
- sample_cnt is 16 bits and wraps modulo 2^16. It is not cleared between ID and RAMP.
- ID sample for channel i = DMA_NP/4 copies of i[3:0].
- RAMP sample for channel i, index j: bits [DMA_NP-1 -: 4] = i[3:0]; bits [7:0] = (sample_cnt + j) mod 256; all other bits 0.
- Phase transition: an accept with beat_cnt = PHASE_BEATS-1 in ID → RAMP, with beat_cnt cleared. The same condition in RAMP → DONE, with dac_valid dropped.
- DONE: start → ID (new sequence); stop → IDLE.
- stop in any state → IDLE next cycle. Outputs return to reset values. stop has priority over start and over an accept in the same cycle.
- start while busy is ignored.
- resetn low mid-sequence: immediate return to IDLE with reset output values.

## Timing
- Reset values: dac_valid 0, dac_data 0, phase 0, busy 0, done 0.
- start sampled in cycle N → dac_valid=1 with beat 0 in cycle N+1.
- All outputs are registered; no combinational path from dac_ready to any output.
- An accept in cycle N → next beat on dac_data in N+1. Back-to-back accepts give one beat per cycle.
- dac_ready low: dac_data and dac_valid hold stable (AXIS-style; valid never retracts except on stop or reset).
- Last RAMP accept in cycle N → N+1: dac_valid 0, done 1, phase 3. dac_data keeps its last value.

## Configuration
- JESD_PATTERN_LOOP_EN defined: the final RAMP accept goes to ID instead of DONE. beat_cnt clears, sample_cnt continues. done is never asserted; only stop ends the run.
- Not defined: the sequence runs once and ends in DONE as described above.

## Structure
- Package jesd_pattern_pkg holds:
  - the state enum;
  - the 2-bit phase encoding constants;
  - the function computing one sample from (phase, channel, index, sample_cnt, DMA_NP).
- Sub-module jesd_pattern_sample_gen: registered builder of the full dac_data word for the next beat. The FSM and counters stay in the top.

## Test plan
All scenarios use M=4, S=2, NP=16, PHASE_BEATS=4 unless noted.
- Reset: hold resetn low with random start/stop → dac_valid 0, dac_data 0, phase 0, busy 0, done 0.
- Nominal run, dac_ready=1, start pulse:
  - 4 ID beats, channel 2 samples = 0x2222;
  - first RAMP beat, channel 1 = 0x1008, 0x1009;
  - channel 3 last beat = 0x300E, 0x300F;
  - then done=1, dac_valid=0.
- Backpressure: dac_ready toggled 1,0,0,1 during RAMP → dac_data stable while ready=0; no sample skipped or repeated; 8 accepts total.
- Abort: stop on the 2nd RAMP accept cycle, then start on the next cycle → IDLE for one cycle; new run restarts at ID with sample_cnt 0.
- Wrap, PHASE_BEATS=200: RAMP beat with sample_cnt=254 carries low bytes 0xFE, 0xFF; the next beat carries 0x00, 0x01.
- JESD_PATTERN_LOOP_EN: after the 4th RAMP accept → phase 1, channel 0 = 0x0000, done stays 0, and the next RAMP starts at sample_cnt 24.
